// File: rtl/reg_hazard_scoreboard_pkg.sv
// rtl/reg_hazard_scoreboard_pkg.sv - shared register-file sizing and pending-counter width helper
package reg_hazard_scoreboard_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int MAX_PEND_DEF = 3;

  // Bits needed to hold 0..max_pend outstanding writes.
  function automatic int pend_cw(input int max_pend);
    return $clog2(max_pend + 1);
  endfunction

endpackage

// File: rtl/reg_hazard_scoreboard_if.sv
// rtl/reg_hazard_scoreboard_if.sv - decode/writeback handshake bundle between decode and the scoreboard
interface reg_hazard_scoreboard_if
  import reg_hazard_scoreboard_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_SRC = 2
);
  logic                      issue_valid;
  logic                      issue_we;
  logic [ADDR_W-1:0]         issue_dst;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*ADDR_W-1:0] src_addr;
  logic                      wb_valid;
  logic [ADDR_W-1:0]         wb_addr;
  logic                      flush;
  logic                      stall;
  logic                      issue_fire;

  modport master (
    output issue_valid, issue_we, issue_dst, src_valid, src_addr,
    output wb_valid, wb_addr, flush,
    input  stall, issue_fire
  );

  modport slave (
    input  issue_valid, issue_we, issue_dst, src_valid, src_addr,
    input  wb_valid, wb_addr, flush,
    output stall, issue_fire
  );
endinterface

// File: rtl/reg_hazard_scoreboard_pend_counter.sv
// rtl/reg_hazard_scoreboard_pend_counter.sv - per-register outstanding-write up/down counter
module pend_counter #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          zero
);

  // Flush wins over everything; a simultaneous issue and writeback cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + CW'(1);
    end else if (dec && !inc) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/reg_hazard_scoreboard.sv
// rtl/reg_hazard_scoreboard.sv - RAW/WAW-saturation hazard scoreboard with stall perf counter
module reg_hazard_scoreboard
  import reg_hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NUM_SRC   = 2,
  parameter int MAX_PEND  = MAX_PEND_DEF,
  parameter int WB_BYPASS = 1,
  parameter int R0_ZERO   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  reg_hazard_scoreboard_if.slave bus,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  err_underflow,
  output logic [31:0]           stall_cycles
);

  localparam int CW    = pend_cw(MAX_PEND);
  localparam int NSLOT = 1 << ADDR_W;

  // One slot per encodable address; slots that are not tracked read as an
  // idle counter, so out-of-range and hardwired-zero addresses never stall.
  logic [CW-1:0]      cnt [NSLOT];
  logic [NSLOT-1:0]   zero_vec;
  logic [NSLOT-1:0]   tracked_vec;
  logic [NUM_SRC-1:0] raw_vec;
  logic               wb_hits_dst;
  logic               waw_sat;
  logic               stall_int;
  logic               fire_int;

  for (genvar r = 0; r < NSLOT; r++) begin : g_reg
    if (r < NUM_REGS && !(R0_ZERO != 0 && r == 0)) begin : g_trk
      logic inc;
      logic dec;
      assign inc = fire_int && bus.issue_we && (bus.issue_dst == ADDR_W'(r));
      assign dec = bus.wb_valid && (bus.wb_addr == ADDR_W'(r)) && !zero_vec[r];
      assign tracked_vec[r] = 1'b1;
      pend_counter #(.CW(CW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (bus.flush),
        .inc   (inc),
        .dec   (dec),
        .count (cnt[r]),
        .zero  (zero_vec[r])
      );
    end else begin : g_untrk
      assign cnt[r]         = '0;
      assign zero_vec[r]    = 1'b1;
      assign tracked_vec[r] = 1'b0;
    end
  end

  // A source is hazarded while any writer is pending, unless the last one
  // retires this very cycle and bypass is enabled.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [ADDR_W-1:0] a;
    logic              bypass;
    assign a        = bus.src_addr[i*ADDR_W +: ADDR_W];
    assign bypass   = (WB_BYPASS != 0) && bus.wb_valid && (bus.wb_addr == a) && (cnt[a] == CW'(1));
    assign raw_vec[i] = bus.src_valid[i] && tracked_vec[a] && !zero_vec[a] && !bypass;
  end

  assign wb_hits_dst = (WB_BYPASS != 0) && bus.wb_valid && (bus.wb_addr == bus.issue_dst);

  // Issue is held on a RAW hazard or when the destination counter is full.
  always_comb begin
    waw_sat   = bus.issue_valid && bus.issue_we &&
                (cnt[bus.issue_dst] == CW'(MAX_PEND)) && !wb_hits_dst;
    stall_int = bus.issue_valid && ((|raw_vec) || waw_sat) && !bus.flush;
    fire_int  = bus.issue_valid && !stall_int;
  end

  assign bus.stall      = stall_int;
  assign bus.issue_fire = fire_int;
  assign busy_vec       = ~zero_vec[NUM_REGS-1:0];

  // Flag a writeback that lands on a tracked register with nothing pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_underflow <= 1'b0;
    end else begin
      err_underflow <= bus.wb_valid && !bus.flush &&
                       tracked_vec[bus.wb_addr] && zero_vec[bus.wb_addr];
    end
  end

  // Count cycles where decode wanted to issue but was held; sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall_int && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// tb/tb_reg_hazard_scoreboard.sv - randomized self-checking bench for reg_hazard_scoreboard
module tb_reg_hazard_scoreboard;
  import reg_hazard_scoreboard_pkg::*;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int MP = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] busy_vec;
  logic          err_underflow;
  logic [31:0]   stall_cycles;

  int n_vec = 0;
  int n_miscomp = 0;

  // Reference state: outstanding writes per register, next underflow pulse, stall count.
  int          pend [NR];
  bit          m_uf;
  logic [31:0] m_sc;

  always #5 clk = ~clk;

  reg_hazard_scoreboard_if #(.ADDR_W(AW), .NUM_SRC(NS)) bus ();

  reg_hazard_scoreboard #(
    .NUM_REGS(NR), .ADDR_W(AW), .NUM_SRC(NS), .MAX_PEND(MP), .WB_BYPASS(1), .R0_ZERO(1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .busy_vec      (busy_vec),
    .err_underflow (err_underflow),
    .stall_cycles  (stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscomp++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < NR; r++) pend[r] = 0;
    m_uf = 1'b0;
  endtask

  // Called at posedge+1: checks outputs for the driven inputs, then advances one edge.
  task automatic step();
    bit          raw, waw, st, fire, inc, dec;
    int          a, d, w;
    logic [NR-1:0] bexp;
    #2;
    raw = 1'b0;
    for (int i = 0; i < NS; i++) begin
      a = int'(bus.src_addr[i*AW +: AW]);
      if (bus.src_valid[i] && a != 0 && pend[a] > 0 &&
          !(bus.wb_valid && int'(bus.wb_addr) == a && pend[a] == 1))
        raw = 1'b1;
    end
    d = int'(bus.issue_dst);
    w = int'(bus.wb_addr);
    waw  = bus.issue_valid && bus.issue_we && pend[d] == MP && !(bus.wb_valid && w == d);
    st   = bus.issue_valid && (raw || waw) && !bus.flush;
    fire = bus.issue_valid && !st;
    for (int r = 0; r < NR; r++) bexp[r] = (pend[r] != 0);
    check("stall", 32'(bus.stall), 32'(st));
    check("issue_fire", 32'(bus.issue_fire), 32'(fire));
    check("busy_vec", busy_vec, bexp);
    check("err_underflow", 32'(err_underflow), 32'(m_uf));
    check("stall_cycles", stall_cycles, m_sc);
    @(posedge clk);
    if (bus.flush) begin
      model_clear();
    end else begin
      inc  = fire && bus.issue_we && d != 0;
      dec  = bus.wb_valid && pend[w] > 0;
      m_uf = bus.wb_valid && w != 0 && pend[w] == 0;
      if (inc) pend[d]++;
      if (dec) pend[w]--;
    end
    if (st && m_sc != 32'hFFFF_FFFF) m_sc++;
    #1;
  endtask

  task automatic drive(input bit iv, input bit we, input int dst, input bit [1:0] sv,
                       input int s0, input int s1, input bit wv, input int wa, input bit fl);
    bus.issue_valid = iv;
    bus.issue_we    = we;
    bus.issue_dst   = AW'(dst);
    bus.src_valid   = sv;
    bus.src_addr    = {AW'(s1), AW'(s0)};
    bus.wb_valid    = wv;
    bus.wb_addr     = AW'(wa);
    bus.flush       = fl;
  endtask

  task automatic go(input bit iv, input bit we, input int dst, input bit [1:0] sv,
                    input int s0, input int s1, input bit wv, input int wa, input bit fl);
    drive(iv, we, dst, sv, s0, s1, wv, wa, fl);
    step();
  endtask

  initial begin
    int q[$];
    int wa;
    reset = 1'b1;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    model_clear();
    m_sc = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    go(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);

    // RAW on r5 until writeback; bypass releases in the writeback cycle.
    go(1, 1, 5, 2'b00, 0, 0, 0, 0, 0);
    go(1, 0, 0, 2'b01, 5, 0, 0, 0, 0);
    go(1, 0, 0, 2'b01, 5, 0, 0, 0, 0);
    go(1, 0, 0, 2'b01, 5, 0, 1, 5, 0);
    check("r5_released", 32'(busy_vec[5]), 32'd0);

    // Saturate r7, then drain.
    repeat (3) go(1, 1, 7, 2'b00, 0, 0, 0, 0, 0);
    go(1, 1, 7, 2'b00, 0, 0, 0, 0, 0);
    check("r7_sat_stall_seen", stall_cycles, m_sc);
    repeat (3) go(0, 0, 0, 2'b00, 0, 0, 1, 7, 0);
    check("r7_drained", 32'(busy_vec[7]), 32'd0);

    // Same-cycle issue and writeback on r9 leaves one pending.
    go(1, 1, 9, 2'b00, 0, 0, 0, 0, 0);
    go(1, 1, 9, 2'b00, 0, 0, 1, 9, 0);
    go(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    check("r9_busy", 32'(busy_vec[9]), 32'd1);
    go(0, 0, 0, 2'b00, 0, 0, 1, 9, 0);

    // r0 is never tracked.
    go(1, 1, 0, 2'b11, 0, 0, 0, 0, 0);
    go(1, 1, 0, 2'b11, 0, 0, 0, 0, 0);
    check("r0_idle", 32'(busy_vec[0]), 32'd0);

    // Underflow on r12 pulses for one cycle.
    go(0, 0, 0, 2'b00, 0, 0, 1, 12, 0);
    check("uf_pulse", 32'(err_underflow), 32'd1);
    go(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    go(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);

    // Flush clears pending r3/r4 and masks the stall in the flush cycle.
    go(1, 1, 3, 2'b00, 0, 0, 0, 0, 0);
    go(1, 1, 4, 2'b00, 0, 0, 0, 0, 0);
    go(1, 1, 6, 2'b11, 3, 4, 0, 0, 1);
    check("flush_busy", busy_vec, 32'd0);
    go(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);

    // Reset asserted mid-stall clears stall and the perf counter at once.
    go(1, 1, 5, 2'b00, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 2'b01, 5, 0, 0, 0, 0);
    #2;
    check("pre_reset_stall", 32'(bus.stall), 32'd1);
    reset = 1'b1;
    #1;
    check("reset_stall", 32'(bus.stall), 32'd0);
    check("reset_sc", stall_cycles, 32'd0);
    check("reset_busy", busy_vec, 32'd0);
    model_clear();
    m_sc = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step();

    // Random traffic over a small register window to provoke hazards.
    for (int n = 0; n < 1500; n++) begin
      q.delete();
      for (int r = 0; r < NR; r++) if (pend[r] > 0) q.push_back(r);
      if (q.size() > 0 && $urandom_range(0, 4) != 0) wa = q[$urandom_range(0, q.size() - 1)];
      else wa = $urandom_range(0, NR - 1);
      go($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 11),
         2'($urandom_range(0, 3)), $urandom_range(0, 11), $urandom_range(0, 11),
         $urandom_range(0, 1) == 1, wa, $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
    $finish;
  end

endmodule
